// File: rtl/ahb_matrix_out_arbiter.sv
// Output-stage arbiter of the AHB bus matrix. It picks which input stage
// drives the shared slave, in round-robin or fixed-priority order. It holds
// the grant across locked transfers and across defined-length bursts, and it
// holds the grant for a bounded time on undefined-length INCR bursts.
//
// Handshake: HREADYM is the only qualifier. A transfer phase is accepted, and
// every register (grant, burst counter, early-INCR counter, RR pointer)
// advances, only on a rising HCLK edge with HREADYM = 1. With HREADYM = 0 all
// state holds. req has no ready; it is sampled level-wise at each accepted edge.
module ahb_matrix_out_arbiter #(
    parameter int                   NUM_PORTS        = 4,
    parameter int                   PORT_W           = 3,
    parameter logic [NUM_PORTS-1:0] PORT_MASK        = 4'hF,
    parameter int                   ARB_MODE         = 0,
    parameter int                   INCR_HOLD_BEATS  = 4,
    parameter int                   EARLY_INCR_LIMIT = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic [NUM_PORTS-1:0] grant_onehot,
    output logic                 burst_hold
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] BURST_WRAP4  = 3'b010;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] BURST_WRAP8  = 3'b100;
    localparam logic [2:0] BURST_INCR8  = 3'b101;
    localparam logic [2:0] BURST_WRAP16 = 3'b110;
    localparam logic [2:0] BURST_INCR16 = 3'b111;

    // Beats still to come after the current one, counted from the NONSEQ.
    localparam logic [3:0] INCR_REMAIN = 4'(INCR_HOLD_BEATS - 2);
    localparam logic [1:0] EARLY_LIMIT = 2'(EARLY_INCR_LIMIT);

    logic [3:0]           remain;
    logic [1:0]           early_cnt;
    logic [PORT_W-1:0]    last_ptr;

    logic [3:0]           remain_nxt;
    logic                 hold_nxt;
    logic [1:0]           early_nxt;
    logic [PORT_W-1:0]    addr_nxt;
    logic                 no_port_nxt;
    logic                 new_grant;

    logic [NUM_PORTS-1:0] eligible;
    logic                 rr_found;
    logic [PORT_W-1:0]    rr_idx;
    logic [PORT_W-1:0]    rr_start;
    logic                 lo_found;
    logic [PORT_W-1:0]    lo_idx;

    function automatic logic bit_at(input logic [NUM_PORTS-1:0] v, input int i);
        logic [NUM_PORTS-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    assign grant_onehot = no_port ? '0 : (NUM_PORTS'(1) << addr_in_port);

    // The granted port is excluded; its continued use is signalled by HSELM.
    assign eligible = req & PORT_MASK & ~grant_onehot;

    // Burst tracking: beats remaining and whether the grant must be held.
    always_comb begin
        remain_nxt = remain;
        hold_nxt   = burst_hold;
        if (!HSELM || HTRANSM == TRANS_IDLE) begin
            remain_nxt = 4'd0;
            hold_nxt   = 1'b0;
        end else begin
            case (HTRANSM)
                TRANS_NONSEQ: begin
                    case (HBURSTM)
                        BURST_INCR16, BURST_WRAP16: begin remain_nxt = 4'd14; hold_nxt = 1'b1; end
                        BURST_INCR8,  BURST_WRAP8:  begin remain_nxt = 4'd6;  hold_nxt = 1'b1; end
                        BURST_INCR4,  BURST_WRAP4:  begin remain_nxt = 4'd2;  hold_nxt = 1'b1; end
                        BURST_INCR: begin
                            if (early_cnt == EARLY_LIMIT) begin
                                remain_nxt = 4'd0;
                                hold_nxt   = 1'b0;
                            end else begin
                                remain_nxt = INCR_REMAIN;
                                hold_nxt   = 1'b1;
                            end
                        end
                        default: begin remain_nxt = 4'd0; hold_nxt = 1'b0; end
                    endcase
                end
                TRANS_SEQ: begin
                    if (remain == 4'd0) hold_nxt = 1'b0;
                    else                remain_nxt = remain - 4'd1;
                end
                default: ; // BUSY keeps counter and hold
            endcase
        end
    end

    // Count INCR bursts cut short by a fresh NONSEQ while still held.
    always_comb begin
        early_nxt = early_cnt;
        if (!hold_nxt)
            early_nxt = 2'd0;
        else if (burst_hold && HTRANSM == TRANS_NONSEQ)
            early_nxt = (early_cnt == 2'd3) ? 2'd3 : early_cnt + 2'd1;
    end

    // Candidate searches: round-robin after a start point, and lowest index.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        rr_start = no_port ? last_ptr : addr_in_port;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!rr_found && bit_at(eligible, (int'(rr_start) + k) % NUM_PORTS)) begin
                rr_found = 1'b1;
                rr_idx   = PORT_W'((int'(rr_start) + k) % NUM_PORTS);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!lo_found && bit_at(eligible, i)) begin
                lo_found = 1'b1;
                lo_idx   = PORT_W'(i);
            end
        end
    end

    // Grant decision for the next accepted cycle.
    always_comb begin
        addr_nxt    = addr_in_port;
        no_port_nxt = no_port;
        new_grant   = 1'b0;
        if (HMASTLOCKM || hold_nxt) begin
            addr_nxt = addr_in_port;
        end else if (no_port) begin
            if (ARB_MODE == 0 && rr_found) begin
                addr_nxt = rr_idx; no_port_nxt = 1'b0; new_grant = 1'b1;
            end else if (ARB_MODE != 0 && lo_found) begin
                addr_nxt = lo_idx; no_port_nxt = 1'b0; new_grant = 1'b1;
            end
        end else if (ARB_MODE == 0) begin
            if (rr_found) begin
                addr_nxt = rr_idx; new_grant = 1'b1;
            end else if (!HSELM) begin
                no_port_nxt = 1'b1;
            end
        end else begin
            if (lo_found && lo_idx < addr_in_port) begin
                addr_nxt = lo_idx; new_grant = 1'b1;
            end else if (HSELM) begin
                addr_nxt = addr_in_port;
            end else if (lo_found) begin
                addr_nxt = lo_idx; new_grant = 1'b1;
            end else begin
                no_port_nxt = 1'b1;
            end
        end
    end

    // State registers, advancing only on accepted (HREADYM) edges.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            burst_hold   <= 1'b0;
            remain       <= 4'd0;
            early_cnt    <= 2'd0;
            last_ptr     <= PORT_W'(NUM_PORTS - 1);
        end else if (HREADYM) begin
            addr_in_port <= addr_nxt;
            no_port      <= no_port_nxt;
            burst_hold   <= hold_nxt;
            remain       <= remain_nxt;
            early_cnt    <= early_nxt;
            if (new_grant) last_ptr <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_matrix_out_arbiter.sv
// Directed bench for ahb_matrix_out_arbiter: a round-robin instance driven
// from a vector table, plus a fixed-priority sparse instance driven by
// hand-written sequences, including an asynchronous reset mid-burst.
module tb_ahb_matrix_out_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR8  = 3'b101;
    localparam logic [2:0] INCR16 = 3'b111;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] req;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;

    logic [2:0] rr_addr;
    logic       rr_np;
    logic [3:0] rr_oh;
    logic       rr_hold;
    logic [2:0] fp_addr;
    logic       fp_np;
    logic [3:0] fp_oh;
    logic       fp_hold;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       sel;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       lock;
        logic       np;
        logic [2:0] addr;
        logic [3:0] oh;
        logic       hold;
    } vec_t;

    vec_t vecs[$];

    ahb_matrix_out_arbiter #(
        .NUM_PORTS(4), .PORT_W(3), .PORT_MASK(4'hF), .ARB_MODE(0),
        .INCR_HOLD_BEATS(4), .EARLY_INCR_LIMIT(1)
    ) dut_rr (
        .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
        .HMASTLOCKM(HMASTLOCKM), .addr_in_port(rr_addr), .no_port(rr_np),
        .grant_onehot(rr_oh), .burst_hold(rr_hold)
    );

    ahb_matrix_out_arbiter #(
        .NUM_PORTS(4), .PORT_W(3), .PORT_MASK(4'b1011), .ARB_MODE(1),
        .INCR_HOLD_BEATS(4), .EARLY_INCR_LIMIT(1)
    ) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
        .HMASTLOCKM(HMASTLOCKM), .addr_in_port(fp_addr), .no_port(fp_np),
        .grant_onehot(fp_oh), .burst_hold(fp_hold)
    );

    // Clock
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] r, input logic rdy, input logic sel,
                           input logic [1:0] tr, input logic [2:0] bu, input logic lk,
                           input logic np, input logic [2:0] ad, input logic [3:0] oh,
                           input logic hd);
        vec_t v;
        v.req = r; v.rdy = rdy; v.sel = sel; v.trans = tr; v.burst = bu; v.lock = lk;
        v.np = np; v.addr = ad; v.oh = oh; v.hold = hd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] r, input logic rdy, input logic sel,
                         input logic [1:0] tr, input logic [2:0] bu, input logic lk);
        req = r; HREADYM = rdy; HSELM = sel; HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk;
    endtask

    // One accepted cycle on the fixed-priority instance, then compare.
    task automatic fp_step(input string name, input logic [3:0] r, input logic sel,
                           input logic [1:0] tr, input logic [2:0] bu,
                           input logic np, input logic [2:0] ad, input logic [3:0] oh,
                           input logic hd);
        drive(r, 1'b1, sel, tr, bu, 1'b0);
        @(posedge HCLK); #1;
        check({name, " np"}, 32'(fp_np), 32'(np));
        check({name, " addr"}, 32'(fp_addr), 32'(ad));
        check({name, " onehot"}, 32'(fp_oh), 32'(oh));
        check({name, " hold"}, 32'(fp_hold), 32'(hd));
    endtask

    initial begin
        // Reset and reset-state checks
        HRESETn = 1'b0;
        drive(4'b0000, 1'b1, 1'b0, IDLE, SINGLE, 1'b0);
        repeat (2) @(posedge HCLK);
        #1;
        check("reset rr np", 32'(rr_np), 32'd1);
        check("reset rr addr", 32'(rr_addr), 32'd0);
        check("reset rr onehot", 32'(rr_oh), 32'd0);
        check("reset rr hold", 32'(rr_hold), 32'd0);
        check("reset fp np", 32'(fp_np), 32'd1);
        HRESETn = 1'b1;

        //       req     rdy  sel  trans   burst   lk    np   addr  onehot   hold
        // first grant from reset: RR search starts after port 3
        add_vec(4'b0100, 1'b1, 1'b0, IDLE,   SINGLE, 1'b0, 1'b0, 3'd2, 4'b0100, 1'b0);
        add_vec(4'b0010, 1'b1, 1'b1, IDLE,   SINGLE, 1'b0, 1'b0, 3'd1, 4'b0010, 1'b0);
        // port 1 in use, competitor 3 next in RR order wins over 0
        add_vec(4'b1001, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0, 3'd3, 4'b1000, 1'b0);
        add_vec(4'b1001, 1'b1, 1'b0, IDLE,   SINGLE, 1'b0, 1'b0, 3'd0, 4'b0001, 1'b0);
        add_vec(4'b0100, 1'b1, 1'b1, IDLE,   SINGLE, 1'b0, 1'b0, 3'd2, 4'b0100, 1'b0);
        // INCR8 on port 2 with req[0] pending, one BUSY inside
        add_vec(4'b0101, 1'b1, 1'b1, NONSEQ, INCR8,  1'b0, 1'b0, 3'd2, 4'b0100, 1'b1);
        add_vec(4'b0101, 1'b1, 1'b1, SEQ,    INCR8,  1'b0, 1'b0, 3'd2, 4'b0100, 1'b1);
        add_vec(4'b0101, 1'b1, 1'b1, SEQ,    INCR8,  1'b0, 1'b0, 3'd2, 4'b0100, 1'b1);
        add_vec(4'b0101, 1'b1, 1'b1, SEQ,    INCR8,  1'b0, 1'b0, 3'd2, 4'b0100, 1'b1);
        add_vec(4'b0101, 1'b1, 1'b1, BUSY,   INCR8,  1'b0, 1'b0, 3'd2, 4'b0100, 1'b1);
        add_vec(4'b0101, 1'b1, 1'b1, SEQ,    INCR8,  1'b0, 1'b0, 3'd2, 4'b0100, 1'b1);
        add_vec(4'b0101, 1'b1, 1'b1, SEQ,    INCR8,  1'b0, 1'b0, 3'd2, 4'b0100, 1'b1);
        add_vec(4'b0101, 1'b1, 1'b1, SEQ,    INCR8,  1'b0, 1'b0, 3'd2, 4'b0100, 1'b1);
        add_vec(4'b0101, 1'b1, 1'b1, SEQ,    INCR8,  1'b0, 1'b0, 3'd0, 4'b0001, 1'b0);
        // back-to-back 2-beat INCR bursts on port 0, port 1 competing
        add_vec(4'b0011, 1'b1, 1'b1, NONSEQ, INCR,   1'b0, 1'b0, 3'd0, 4'b0001, 1'b1);
        add_vec(4'b0011, 1'b1, 1'b1, SEQ,    INCR,   1'b0, 1'b0, 3'd0, 4'b0001, 1'b1);
        add_vec(4'b0011, 1'b1, 1'b1, NONSEQ, INCR,   1'b0, 1'b0, 3'd0, 4'b0001, 1'b1);
        add_vec(4'b0011, 1'b1, 1'b1, SEQ,    INCR,   1'b0, 1'b0, 3'd0, 4'b0001, 1'b1);
        add_vec(4'b0011, 1'b1, 1'b1, NONSEQ, INCR,   1'b0, 1'b0, 3'd1, 4'b0010, 1'b0);
        // locked IDLE transfers with all requests up
        add_vec(4'b1111, 1'b1, 1'b1, IDLE,   SINGLE, 1'b1, 1'b0, 3'd1, 4'b0010, 1'b0);
        add_vec(4'b1111, 1'b1, 1'b1, IDLE,   SINGLE, 1'b1, 1'b0, 3'd1, 4'b0010, 1'b0);
        add_vec(4'b1111, 1'b1, 1'b1, IDLE,   SINGLE, 1'b1, 1'b0, 3'd1, 4'b0010, 1'b0);
        add_vec(4'b1111, 1'b1, 1'b1, IDLE,   SINGLE, 1'b0, 1'b0, 3'd2, 4'b0100, 1'b0);
        // wait states freeze everything
        add_vec(4'b1111, 1'b0, 1'b0, IDLE,   SINGLE, 1'b0, 1'b0, 3'd2, 4'b0100, 1'b0);
        add_vec(4'b1111, 1'b0, 1'b0, IDLE,   SINGLE, 1'b0, 1'b0, 3'd2, 4'b0100, 1'b0);
        add_vec(4'b1111, 1'b0, 1'b0, IDLE,   SINGLE, 1'b0, 1'b0, 3'd2, 4'b0100, 1'b0);
        // release to no_port, addr keeps 2; then RR resumes after last_ptr = 2
        add_vec(4'b0000, 1'b1, 1'b0, IDLE,   SINGLE, 1'b0, 1'b1, 3'd2, 4'b0000, 1'b0);
        add_vec(4'b1010, 1'b1, 1'b0, IDLE,   SINGLE, 1'b0, 1'b0, 3'd3, 4'b1000, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].rdy, vecs[i].sel, vecs[i].trans, vecs[i].burst, vecs[i].lock);
            @(posedge HCLK); #1;
            check($sformatf("vec%0d np", i), 32'(rr_np), 32'(vecs[i].np));
            check($sformatf("vec%0d addr", i), 32'(rr_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d onehot", i), 32'(rr_oh), 32'(vecs[i].oh));
            check($sformatf("vec%0d hold", i), 32'(rr_hold), 32'(vecs[i].hold));
        end

        // Fixed priority, sparse mask 4'b1011: port 2 is never granted
        HRESETn = 1'b0;
        drive(4'b0000, 1'b1, 1'b0, IDLE, SINGLE, 1'b0);
        #1;
        check("fp reset np", 32'(fp_np), 32'd1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        fp_step("fp grant3",     4'b1000, 1'b0, IDLE,   SINGLE, 1'b0, 3'd3, 4'b1000, 1'b0);
        fp_step("fp to0",        4'b0101, 1'b1, IDLE,   SINGLE, 1'b0, 3'd0, 4'b0001, 1'b0);
        fp_step("fp release",    4'b0100, 1'b0, IDLE,   SINGLE, 1'b1, 3'd0, 4'b0000, 1'b0);
        fp_step("fp masked",     4'b0100, 1'b0, IDLE,   SINGLE, 1'b1, 3'd0, 4'b0000, 1'b0);
        fp_step("fp lowest1",    4'b1010, 1'b0, IDLE,   SINGLE, 1'b0, 3'd1, 4'b0010, 1'b0);
        fp_step("fp keep1",      4'b1000, 1'b1, IDLE,   SINGLE, 1'b0, 3'd1, 4'b0010, 1'b0);
        fp_step("fp preempt0",   4'b1001, 1'b1, IDLE,   SINGLE, 1'b0, 3'd0, 4'b0001, 1'b0);
        fp_step("fp higher",     4'b1010, 1'b0, IDLE,   SINGLE, 1'b0, 3'd1, 4'b0010, 1'b0);
        fp_step("fp incr16",     4'b0001, 1'b1, NONSEQ, INCR16, 1'b0, 3'd1, 4'b0010, 1'b1);
        fp_step("fp incr16 seq", 4'b0001, 1'b1, SEQ,    INCR16, 1'b0, 3'd1, 4'b0010, 1'b1);

        // Asynchronous reset mid-burst, between clock edges
        #3;
        HRESETn = 1'b0;
        #1;
        check("async rst fp np", 32'(fp_np), 32'd1);
        check("async rst fp hold", 32'(fp_hold), 32'd0);
        check("async rst fp onehot", 32'(fp_oh), 32'd0);
        check("async rst fp addr", 32'(fp_addr), 32'd0);
        check("async rst rr np", 32'(rr_np), 32'd1);
        check("async rst rr hold", 32'(rr_hold), 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        fp_step("fp after rst", 4'b0100, 1'b0, IDLE, SINGLE, 1'b1, 3'd0, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
